// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl
// Drives NUM_DIGITS common-anode digits from one shared hex-to-7-segment
// decoder. A pending buffer takes loads from the datapath. The active buffer
// that feeds the display is only replaced at the end of a frame, so every
// digit in a frame comes from the same snapshot. The first BLANK_CYCLES of
// each digit slot keep all anodes off, which lets the decoder settle on the
// new digit before that digit is lit.

module display_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  output logic [3:0]              values,
  input  logic [6:0]              leds_in,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick,
  output logic                    pending
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0]      CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] ONE_HOT   = NUM_DIGITS'(1);
  localparam logic [6:0]            SEG_OFF   = 7'b1111111;

  typedef enum logic {
    PH_BLANK,
    PH_SHOW
  } phase_t;

  logic [CNT_W-1:0]        r_cnt;
  logic [IDX_W-1:0]        r_idx;
  logic [4*NUM_DIGITS-1:0] r_active;
  logic [NUM_DIGITS-1:0]   r_activeMask;
  logic [4*NUM_DIGITS-1:0] r_pendData;
  logic [NUM_DIGITS-1:0]   r_pendMask;
  logic                    r_pending;
  logic [NUM_DIGITS-1:0]   r_an;
  logic [6:0]              r_seg;
  logic                    r_frameTick;

  phase_t                  w_phase;
  logic [CNT_W-1:0]        w_cntNext;
  logic [IDX_W-1:0]        w_idxNext;
  logic                    w_commit;
  logic [NUM_DIGITS-1:0]   w_anNext;
  logic [6:0]              w_segNext;

  // The current digit's nibble goes straight to the decoder in both phases,
  // so the decoder output is already stable by the time the anode turns on.
  assign values     = r_active[{r_idx, 2'b00} +: 4];
  assign seg        = r_seg;
  assign an         = r_an;
  assign frame_tick = r_frameTick;
  assign pending    = r_pending;

  // Next-state and output decode: phase from the slot counter, counter and
  // index advance, and the last cycle of the frame marked as the commit edge.
  always_comb begin
    w_phase   = PH_SHOW;
    w_cntNext = r_cnt + CNT_W'(1);
    w_idxNext = r_idx;
    w_commit  = 1'b0;
    w_anNext  = '1;
    w_segNext = SEG_OFF;
    if (r_cnt < CNT_BLANK) begin
      w_phase = PH_BLANK;
    end
    if (r_cnt == CNT_LAST) begin
      w_cntNext = '0;
      if (r_idx == IDX_LAST) begin
        w_idxNext = '0;
        w_commit  = 1'b1;
      end else begin
        w_idxNext = r_idx + IDX_W'(1);
      end
    end
    if (w_phase == PH_SHOW) begin
      w_anNext  = ~(ONE_HOT << r_idx);
      w_segNext = r_activeMask[r_idx] ? SEG_OFF : leds_in;
    end
  end

  // Scan position state: slot counter and digit index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else begin
      r_cnt <= w_cntNext;
      r_idx <= w_idxNext;
    end
  end

  // Double buffer. A load that lands on the commit edge goes straight into
  // the active buffer, so it is not left waiting for another frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_active     <= '0;
      r_activeMask <= '0;
      r_pendData   <= '0;
      r_pendMask   <= '0;
      r_pending    <= 1'b0;
    end else begin
      if (load) begin
        r_pendData <= data_in;
        r_pendMask <= blank_mask;
      end
      if (w_commit) begin
        r_pending <= 1'b0;
        if (load) begin
          r_active     <= data_in;
          r_activeMask <= blank_mask;
        end else if (r_pending) begin
          r_active     <= r_pendData;
          r_activeMask <= r_pendMask;
        end
      end else if (load) begin
        r_pending <= 1'b1;
      end
    end
  end

  // Registered pin drivers. Each pin value follows the scan position by one
  // cycle, and the frame tick marks every commit edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_an        <= '1;
      r_seg       <= SEG_OFF;
      r_frameTick <= 1'b0;
    end else begin
      r_an        <= w_anNext;
      r_seg       <= w_segNext;
      r_frameTick <= w_commit;
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Testbench for display_scan_ctrl using a small configuration: 4 digits,
// 8-cycle slots and a 2-cycle blanking guard, which gives a 32-cycle frame.
// A cycle-based reference model pushes the expected pin state for each clock
// edge into a queue. A checker on the falling edge pops each entry and
// compares it with the DUT outputs.

module tb_display_scan_ctrl;

  localparam int N     = 4;
  localparam int RD    = 8;
  localparam int BC    = 2;
  localparam int FRAME = N * RD;

  logic          clk;
  logic          rst;
  logic          load;
  logic [15:0]   data_in;
  logic [3:0]    blank_mask;
  logic [3:0]    values;
  logic [6:0]    leds_in;
  logic [6:0]    seg;
  logic [3:0]    an;
  logic          frame_tick;
  logic          pending;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       tick;
    logic       pend;
    logic [3:0] val;
  } expect_t;

  expect_t sbQueue[$];

  int checkCount;
  int errorCount;
  int activeCycles;

  int          mT;
  int          mIdx;
  int          mCnt;
  logic [15:0] mActive;
  logic [3:0]  mMask;
  logic [15:0] mPendData;
  logic [3:0]  mPendMask;
  logic        mPend;
  expect_t     mExp;
  expect_t     cExp;

  display_scan_ctrl #(
    .NUM_DIGITS  (N),
    .REFRESH_DIV (RD),
    .BLANK_CYCLES(BC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .data_in   (data_in),
    .blank_mask(blank_mask),
    .values    (values),
    .leds_in   (leds_in),
    .seg       (seg),
    .an        (an),
    .frame_tick(frame_tick),
    .pending   (pending)
  );

  // The external shared decoder: hex to active-low segments {a,b,c,d,e,f,g}.
  function automatic logic [6:0] segDecode(input logic [3:0] v);
    case (v)
      4'h0: return 7'b0000001;
      4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;
      4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;
      4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;
      4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0000100;
      4'hA: return 7'b0001000;
      4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;
      4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;
      default: return 7'b0111000;
    endcase
  endfunction

  assign leds_in = segDecode(values);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Drive one load strobe. The caller is at a falling edge.
  task automatic applyStimulus(input logic [15:0] data, input logic [3:0] mask);
    load       = 1'b1;
    data_in    = data;
    blank_mask = mask;
    @(negedge clk);
    load       = 1'b0;
  endtask

  // Wait on falling edges until the DUT's scan position equals the given
  // frame cycle. The wait is bounded.
  task automatic waitFor(input int target);
    int guard;
    guard = 0;
    while (mT != target && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (mT != target) checkOutput("waitTimeout", mT, target);
  endtask

  // Reference model: frame position as a single cycle count. Expected pins
  // follow from the pre-edge position and snapshot.
  initial begin
    mT = 0; mActive = '0; mMask = '0; mPendData = '0; mPendMask = '0; mPend = 1'b0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        mT = 0; mActive = '0; mMask = '0; mPendData = '0; mPendMask = '0; mPend = 1'b0;
        sbQueue.delete();
      end else begin
        mIdx = mT / RD;
        mCnt = mT % RD;
        mExp.tick = (mT == FRAME - 1);
        if (mCnt < BC) begin
          mExp.an  = 4'hF;
          mExp.seg = 7'h7F;
        end else begin
          mExp.an  = ~(4'b0001 << mIdx);
          mExp.seg = mMask[mIdx] ? 7'h7F : segDecode(mActive[mIdx*4 +: 4]);
        end
        if (mT == FRAME - 1) begin
          if (load) begin
            mActive = data_in;
            mMask   = blank_mask;
          end else if (mPend) begin
            mActive = mPendData;
            mMask   = mPendMask;
          end
          mPend = 1'b0;
        end else if (load) begin
          mPendData = data_in;
          mPendMask = blank_mask;
          mPend     = 1'b1;
        end
        mExp.pend = mPend;
        mT = (mT + 1) % FRAME;
        mExp.val = mActive[(mT / RD)*4 +: 4];
        sbQueue.push_back(mExp);
      end
    end
  end

  // Scoreboard checker on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && sbQueue.size() > 0) begin
        cExp = sbQueue.pop_front();
        checkOutput("an", an, cExp.an);
        checkOutput("seg", seg, cExp.seg);
        checkOutput("frameTick", frame_tick, cExp.tick);
        checkOutput("pending", pending, cExp.pend);
        checkOutput("values", values, cExp.val);
        checkOutput("anOneLow", ($countones(~an) <= 1), 1);
      end
    end
  end

  initial begin
    checkCount = 0;
    errorCount = 0;
    rst        = 1'b1;
    load       = 1'b0;
    data_in    = '0;
    blank_mask = '0;

    // Reset held for three cycles.
    repeat (3) @(negedge clk);
    checkOutput("resetAn", an, 4'hF);
    checkOutput("resetSeg", seg, 7'h7F);
    checkOutput("resetTick", frame_tick, 0);
    checkOutput("resetPending", pending, 0);
    checkOutput("resetValues", values, 0);
    rst = 1'b0;

    // One full frame with no load: 6 lit cycles per digit.
    activeCycles = 0;
    repeat (FRAME) begin
      @(negedge clk);
      if (an != 4'hF) activeCycles++;
    end
    checkOutput("anActiveCycles", activeCycles, 24);

    // Load in mid-frame. The load waits in the pending buffer until the commit edge.
    waitFor(10);
    applyStimulus(16'h4321, 4'b0000);
    checkOutput("pendingAfterLoad", pending, 1);
    waitFor(FRAME - 1);
    @(negedge clk);
    checkOutput("commitTick", frame_tick, 1);
    checkOutput("commitPending", pending, 0);
    waitFor(4);
    checkOutput("digit0Seg", seg, 7'b1001111);
    checkOutput("digit0An", an, 4'b1110);
    waitFor(FRAME - 4);
    checkOutput("digit3An", an, 4'b0111);

    // Two loads in one frame. The later load is the one committed.
    waitFor(5);
    applyStimulus(16'hAAAA, 4'b0000);
    waitFor(12);
    applyStimulus(16'hBBBB, 4'b0000);
    waitFor(FRAME - 1);
    @(negedge clk);
    checkOutput("lastWinsPending", pending, 0);
    waitFor(4);
    checkOutput("lastWinsSeg", seg, 7'b1100000);

    // A load on the commit cycle is committed directly.
    waitFor(FRAME - 1);
    applyStimulus(16'hF00F, 4'b0110);
    checkOutput("edgeLoadPending", pending, 0);
    checkOutput("edgeLoadTick", frame_tick, 1);
    waitFor(12);
    checkOutput("maskedDigit1An", an, 4'b1101);
    checkOutput("maskedDigit1Seg", seg, 7'h7F);
    waitFor(4);
    checkOutput("digitFSeg", seg, 7'b0111000);

    // Asynchronous reset during SHOW of digit 2 while a load is pending.
    waitFor(1);
    applyStimulus(16'h9876, 4'b0000);
    waitFor(20);
    @(posedge clk);
    #1;
    checkOutput("preResetAn", an, 4'b1011);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("asyncResetAn", an, 4'hF);
    checkOutput("asyncResetSeg", seg, 7'h7F);
    checkOutput("asyncResetPending", pending, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    waitFor(4);
    checkOutput("postResetAn", an, 4'b1110);
    checkOutput("postResetSeg", seg, 7'b0000001);
    repeat (FRAME) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
